// File: rtl/mux_pkg.sv
// Shared definitions for the N:1 pipelined mux: skid-buffer state encoding,
// select-width helper and default geometry.
package mux_pkg;

    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b10;

    localparam int DEF_WIDTH  = 5;
    localparam int DEF_NUM_IN = 3;

    // ceil(log2(n)), never below 1 so a 2-input mux still has a select bit
    function automatic int sel_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/mux_skid_buf.sv
// Two-entry skid buffer (main output register + one skid register) with a
// registered ready, so out_ready never reaches in_ready combinationally.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | nothing buffered, out_valid low
// ST_ONE   | main register holds the head beat
// ST_FULL  | main holds the head, skid holds the next beat
module mux_skid_buf
    import mux_pkg::*;
#(
    parameter int PW = DEF_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          in_valid_i,
    input  logic [PW-1:0] in_pl_i,
    output logic          in_ready_o,
    output logic          out_valid_o,
    output logic [PW-1:0] out_pl_o,
    input  logic          out_ready_i
);

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] main_q, main_d;
    logic [PW-1:0] skid_q, skid_d;
    logic          ready_q;
    logic          in_xfer;
    logic          out_xfer;

    assign out_valid_o = (state_q != ST_EMPTY);
    assign out_pl_o    = main_q;
    assign in_ready_o  = ready_q;
    assign in_xfer     = in_valid_i && ready_q;
    assign out_xfer    = out_valid_o && out_ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        main_d  = in_pl_i;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_d = in_pl_i;
                    end else if (in_xfer) begin
                        skid_d  = in_pl_i;
                        state_d = ST_FULL;
                    end else if (out_xfer) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_xfer) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // ready is computed from the next state so it is already valid the cycle the skid fills
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ready_q <= (state_d != ST_FULL);
        end
    end

endmodule

// File: rtl/mux_n_1_pipe.sv
// N:1 channel mux feeding a 2-entry skid buffer; out-of-range selects fall
// through to the last channel. Define MUX_SEL_ERR_EN to carry a select-error flag.
module mux_n_1_pipe
    import mux_pkg::*;
#(
    parameter  int WIDTH  = DEF_WIDTH,
    parameter  int NUM_IN = DEF_NUM_IN,
    localparam int SEL_W  = sel_width(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_sel_err
);

`ifdef MUX_SEL_ERR_EN
    localparam int PW = WIDTH + 1;
`else
    localparam int PW = WIDTH;
`endif

    logic [WIDTH-1:0] sel_data;
    logic [PW-1:0]    in_pl;
    logic [PW-1:0]    out_pl;

    always_comb begin
        sel_data = in_data[(NUM_IN-1)*WIDTH +: WIDTH];
        for (int k = 0; k < NUM_IN - 1; k++) begin
            if (int'(in_sel) == k) sel_data = in_data[k*WIDTH +: WIDTH];
        end
    end

`ifdef MUX_SEL_ERR_EN
    logic sel_err;
    assign sel_err     = (int'(in_sel) >= NUM_IN);
    assign in_pl       = {sel_err, sel_data};
    assign out_data    = out_pl[WIDTH-1:0];
    assign out_sel_err = out_pl[WIDTH];
`else
    assign in_pl       = sel_data;
    assign out_data    = out_pl;
    assign out_sel_err = 1'b0;
`endif

    mux_skid_buf #(
        .PW (PW)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_pl_i     (in_pl),
        .in_ready_o  (in_ready),
        .out_valid_o (out_valid),
        .out_pl_o    (out_pl),
        .out_ready_i (out_ready)
    );

endmodule

// File: doc/mux_n_1_pipe.md
MUX_N_1_PIPE -- requirements
Module: mux_n_1_pipe

Interface
REQ-001 Parameter: WIDTH, default 5, data width per channel in bits (1..32).
REQ-002 Parameter: NUM_IN, default 3, number of input channels (2..16).
REQ-003 Derived constant: SEL_W = ceil(log2(NUM_IN)), minimum 1.
REQ-004 Port: clk  in  1  single clock; all state updates on the rising edge.
REQ-005 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-006 Port: in_data  in  NUM_IN*WIDTH  flattened channels; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 Port: in_sel  in  SEL_W  channel select, qualified by in_valid.
REQ-008 Port: in_valid  in  1  the upstream beat is present.
REQ-009 Port: in_ready  out  1  the block accepts a beat this cycle.
REQ-010 Port: flush  in  1  synchronous discard of all buffered beats.
REQ-011 Port: out_data  out  WIDTH  selected channel value, registered.
REQ-012 Port: out_valid  out  1  out_data is valid.
REQ-013 Port: out_ready  in  1  downstream consumes the beat when high together with out_valid.
REQ-014 Port: out_sel_err  out  1  the beat on out_data was captured with an out-of-range select.

Function
REQ-015 A beat transfers on input when in_valid && in_ready, and on output when out_valid && out_ready.
REQ-016 A transferred beat captures the slice of in_data selected by in_sel; in_sel >= NUM_IN captures channel NUM_IN-1 (fall-through to the last channel).
REQ-017 Latency is exactly 1 cycle from an input transfer to out_valid when the output stage is empty or draining.
REQ-018 Buffering is a 2-entry skid: a main (output) register plus one skid register; in_ready = !skid_full, registered, with no combinational path from out_ready.
REQ-019 State machine EMPTY/ONE/FULL:
- EMPTY + in transfer -> ONE.
- ONE + in transfer without out transfer -> FULL.
- ONE + out transfer without in transfer -> EMPTY.
- ONE + both -> ONE.
- FULL + out transfer -> ONE, with the skid entry moving into the main register.
REQ-020 Order is strict FIFO; no beat is dropped or duplicated.
REQ-021 out_data and out_sel_err are held stable while out_valid && !out_ready.
REQ-022 flush forces the state to EMPTY on the next edge and takes priority over a simultaneous input or output transfer; a beat offered in the flush cycle is discarded.
REQ-023 out_data holds its last value when out_valid is low, and is never X after reset.

Reset
REQ-024 On rst_n low, asynchronously:
- state = EMPTY;
- out_valid = 0, out_data = 0, out_sel_err = 0;
- in_ready = 0 while rst_n is low, and 1 from the first edge after deassertion.
REQ-025 Reset asserted mid-transfer discards all buffered beats; no partial beat survives.

Configuration
REQ-026 Macro MUX_SEL_ERR_EN: when defined, out_sel_err carries a per-entry flag set when the captured in_sel >= NUM_IN, travelling with the beat through both entries.
REQ-027 When MUX_SEL_ERR_EN is not defined, out_sel_err is tied to 0 and no flag storage is built; data behaviour is identical in both builds.

Structure
REQ-028 Shared package mux_pkg holds the state encoding (EMPTY=2'b00, ONE=2'b01, FULL=2'b10), the select-width function, and the default constants WIDTH=5 and NUM_IN=3.
REQ-029 The skid storage and state machine are a sub-module mux_skid_buf, parametrised on payload width (WIDTH, plus 1 when MUX_SEL_ERR_EN is defined); mux_n_1_pipe holds the selection logic and instantiates it.

Verification
REQ-030 Defaults; channels = 5'h0A/5'h15/5'h1F; in_sel = 0,1,2 on consecutive cycles with out_ready=1 -> out_data = 0A, 15, 1F, each one cycle after its transfer; out_valid continuous.
REQ-031 in_sel = 3 with channel 2 = 5'h1F -> out_data = 1F; out_sel_err = 1 with MUX_SEL_ERR_EN defined, 0 without.
REQ-032 out_ready = 0, three beats offered -> two accepted and in_ready = 0 on the cycle after the second; raise out_ready -> both emerge in order, then the third is accepted.
REQ-033 State FULL, flush = 1 together with in_valid = 1 -> next cycle out_valid = 0, in_ready = 1, nothing emitted.
REQ-034 rst_n pulsed low asynchronously while FULL -> out_valid = 0, out_data = 0 immediately; in_ready = 1 after the first post-reset edge.
REQ-035 WIDTH=8, NUM_IN=16, random in_valid/out_ready for 10k cycles against a scoreboard -> zero mismatches, losses or duplicates.
